// File: rtl/fft_session_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_session_pkg
//  Description : Shared constants and types for the FFT session controller:
//                command opcodes, status codes, crossbar control words, the
//                controller state enum and the status-word packing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_session_pkg;

   // Command opcodes carried in cmd_recv_msg[1:0]
   localparam logic [1:0] OP_NOP    = 2'd0;
   localparam logic [1:0] OP_START  = 2'd1;
   localparam logic [1:0] OP_ABORT  = 2'd2;
   localparam logic [1:0] OP_STATUS = 2'd3;

   // Status codes carried in status_send_msg[15:14]
   localparam logic [1:0] STAT_DONE    = 2'b00;
   localparam logic [1:0] STAT_ABORTED = 2'b01;
   localparam logic [1:0] STAT_TIMEOUT = 2'b10;
   localparam logic [1:0] STAT_QUERY   = 2'b11;

   // Crossbar control words, {input sel, output sel}
   localparam logic [1:0] XBAR_SPI_TO_FFT = 2'b01;
   localparam logic [1:0] XBAR_FFT_TO_SPI = 2'b10;
   localparam logic [1:0] XBAR_LOOPBACK   = 2'b00;

   // Width of each count field inside the status word
   localparam int STATUS_CNT_BITS = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CFG_IN  = 3'd1,
      ST_CFG_OUT = 3'd2,
      ST_LOAD    = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_RST_IN  = 3'd5,
      ST_RST_OUT = 3'd6,
      ST_REPORT  = 3'd7
   } state_e;

   // Status word layout: {code, in_cnt, 2'b00, out_cnt}
   function automatic logic [15:0] pack_status(
      input logic [1:0]                 code,
      input logic [STATUS_CNT_BITS-1:0] in_cnt,
      input logic [STATUS_CNT_BITS-1:0] out_cnt
   );
      return {code, in_cnt, 2'b00, out_cnt};
   endfunction

endpackage : fft_session_pkg
`default_nettype wire

// File: rtl/session_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : session_beat_counter
//  Description : Saturating beat counter with an idle watchdog. The watchdog
//                runs only while 'active' is high and restarts on every
//                counted beat.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                clr               - clear count and watchdog
//                active            - owning phase is in progress
//                inc               - a counted beat fires this cycle
//                cnt               - current beat count (saturates)
//                reach_full        - this cycle's beat brings cnt to N_SAMPLES
//                timeout           - watchdog expired with no beat this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module session_beat_counter #(
   parameter int N_SAMPLES      = 32,
   parameter int CNT_BITS       = 6,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                active,
   input  logic                inc,
   output logic [CNT_BITS-1:0] cnt,
   output logic                reach_full,
   output logic                timeout
);

   localparam int                WD_BITS  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(N_SAMPLES);
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(N_SAMPLES - 1);
   localparam logic [WD_BITS-1:0]  WD_LAST  = WD_BITS'(TIMEOUT_CYCLES - 1);

   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [WD_BITS-1:0]  wd_q,  wd_d;

   always_comb begin
      cnt_d = cnt_q;
      wd_d  = wd_q;
      if (clr) begin
         cnt_d = '0;
         wd_d  = '0;
      end else begin
         if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (active) begin
            if (inc) begin
               wd_d = '0;
            end else if (wd_q != WD_LAST) begin
               // Holds at the last value; the owner leaves the phase on expiry
               wd_d = wd_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         wd_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         wd_q  <= wd_d;
      end
   end

   assign cnt        = cnt_q;
   assign reach_full = inc && (cnt_q == CNT_LAST);
   assign timeout    = active && !inc && (wd_q == WD_LAST);

endmodule : session_beat_counter
`default_nettype wire

// File: rtl/fft_session_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fft_session_controller
//  Description : Sequences one FFT job: accepts commands, programs the input
//                and output crossbars, counts sample beats in and out,
//                restores both crossbars to SPI loopback and returns a status
//                word. All outputs are registered.
//  Ports       : clk, reset                  - clock, sync active-high reset
//                cmd_recv_msg/val/rdy        - 16-bit command input
//                in_ctrl_msg/val/rdy         - input crossbar control
//                out_ctrl_msg/val/rdy        - output crossbar control
//                in_beat_val/rdy             - observed deserializer beats
//                out_beat_val/rdy            - observed serializer beats
//                status_send_msg/val/rdy     - 16-bit status output
//                busy                        - high outside IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module fft_session_controller
   import fft_session_pkg::*;
#(
   parameter int N_SAMPLES      = 32,
   parameter int CNT_BITS       = 6,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cmd_recv_msg,
   input  logic        cmd_recv_val,
   output logic        cmd_recv_rdy,
   output logic [1:0]  in_ctrl_msg,
   output logic        in_ctrl_val,
   input  logic        in_ctrl_rdy,
   output logic [1:0]  out_ctrl_msg,
   output logic        out_ctrl_val,
   input  logic        out_ctrl_rdy,
   input  logic        in_beat_val,
   input  logic        in_beat_rdy,
   input  logic        out_beat_val,
   input  logic        out_beat_rdy,
   output logic [15:0] status_send_msg,
   output logic        status_send_val,
   input  logic        status_send_rdy,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [1:0]  code_q,  code_d;

   logic        cmd_recv_rdy_q,    cmd_recv_rdy_d;
   logic        in_ctrl_val_q,     in_ctrl_val_d;
   logic [1:0]  in_ctrl_msg_q,     in_ctrl_msg_d;
   logic        out_ctrl_val_q,    out_ctrl_val_d;
   logic [1:0]  out_ctrl_msg_q,    out_ctrl_msg_d;
   logic        status_send_val_q, status_send_val_d;
   logic [15:0] status_send_msg_q, status_send_msg_d;
   logic        busy_q,            busy_d;

   logic                cmd_fire;
   logic [1:0]          cmd_op;
   logic                cmd_abort;
   logic                cnt_clr;
   logic                in_active,  out_active;
   logic                in_inc,     out_inc;
   logic                in_full,    out_full;
   logic                in_timeout, out_timeout;
   logic [CNT_BITS-1:0] in_cnt,     out_cnt;
   logic                unused_cmd_bits;

   assign cmd_op          = cmd_recv_msg[1:0];
   assign unused_cmd_bits = ^cmd_recv_msg[15:2];
   assign cmd_fire        = cmd_recv_val && cmd_recv_rdy_q;
   assign cmd_abort       = cmd_fire && (cmd_op == OP_ABORT);

   // Beats are counted only in their own phase; fires elsewhere are ignored
   assign in_active  = (state_q == ST_LOAD);
   assign out_active = (state_q == ST_DRAIN);
   assign in_inc     = in_active  && in_beat_val  && in_beat_rdy;
   assign out_inc    = out_active && out_beat_val && out_beat_rdy;

   session_beat_counter #(
      .N_SAMPLES      (N_SAMPLES),
      .CNT_BITS       (CNT_BITS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_in_counter (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .active     (in_active),
      .inc        (in_inc),
      .cnt        (in_cnt),
      .reach_full (in_full),
      .timeout    (in_timeout)
   );

   session_beat_counter #(
      .N_SAMPLES      (N_SAMPLES),
      .CNT_BITS       (CNT_BITS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_out_counter (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .active     (out_active),
      .inc        (out_inc),
      .cnt        (out_cnt),
      .reach_full (out_full),
      .timeout    (out_timeout)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      cnt_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               if (cmd_op == OP_START) begin
                  cnt_clr = 1'b1;
                  state_d = ST_CFG_IN;
               end else if (cmd_op == OP_STATUS) begin
                  code_d  = STAT_QUERY;
                  state_d = ST_REPORT;
               end
            end
         end
         ST_CFG_IN: begin
            if (in_ctrl_val_q && in_ctrl_rdy) begin
               state_d = ST_CFG_OUT;
            end
         end
         ST_CFG_OUT: begin
            if (out_ctrl_val_q && out_ctrl_rdy) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // ABORT outranks completion and timeout; a coincident beat
            // is still counted by the counter instance.
            if (cmd_abort) begin
               code_d  = STAT_ABORTED;
               state_d = ST_RST_IN;
            end else if (in_full) begin
               state_d = ST_DRAIN;
            end else if (in_timeout) begin
               code_d  = STAT_TIMEOUT;
               state_d = ST_RST_IN;
            end
         end
         ST_DRAIN: begin
            if (cmd_abort) begin
               code_d  = STAT_ABORTED;
               state_d = ST_RST_IN;
            end else if (out_full) begin
               code_d  = STAT_DONE;
               state_d = ST_RST_IN;
            end else if (out_timeout) begin
               code_d  = STAT_TIMEOUT;
               state_d = ST_RST_IN;
            end
         end
         ST_RST_IN: begin
            if (in_ctrl_val_q && in_ctrl_rdy) begin
               state_d = ST_RST_OUT;
            end
         end
         ST_RST_OUT: begin
            if (out_ctrl_val_q && out_ctrl_rdy) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (status_send_val_q && status_send_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so that they register
   // together with the state and line up with it cycle for cycle.
   always_comb begin
      cmd_recv_rdy_d    = (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                          (state_d == ST_DRAIN);
      in_ctrl_val_d     = (state_d == ST_CFG_IN)  || (state_d == ST_RST_IN);
      in_ctrl_msg_d     = (state_d == ST_CFG_IN)  ? XBAR_SPI_TO_FFT : XBAR_LOOPBACK;
      out_ctrl_val_d    = (state_d == ST_CFG_OUT) || (state_d == ST_RST_OUT);
      out_ctrl_msg_d    = (state_d == ST_CFG_OUT) ? XBAR_FFT_TO_SPI : XBAR_LOOPBACK;
      busy_d            = (state_d != ST_IDLE);
      status_send_val_d = (state_d == ST_REPORT);
      status_send_msg_d = '0;
      if (state_d == ST_REPORT) begin
         // Capture once on entry, then hold stable until accepted
         if (state_q == ST_REPORT) begin
            status_send_msg_d = status_send_msg_q;
         end else begin
            status_send_msg_d = pack_status(code_d,
                                            STATUS_CNT_BITS'(in_cnt),
                                            STATUS_CNT_BITS'(out_cnt));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         code_q            <= STAT_DONE;
         cmd_recv_rdy_q    <= 1'b1;
         in_ctrl_val_q     <= 1'b0;
         in_ctrl_msg_q     <= '0;
         out_ctrl_val_q    <= 1'b0;
         out_ctrl_msg_q    <= '0;
         status_send_val_q <= 1'b0;
         status_send_msg_q <= '0;
         busy_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         code_q            <= code_d;
         cmd_recv_rdy_q    <= cmd_recv_rdy_d;
         in_ctrl_val_q     <= in_ctrl_val_d;
         in_ctrl_msg_q     <= in_ctrl_msg_d;
         out_ctrl_val_q    <= out_ctrl_val_d;
         out_ctrl_msg_q    <= out_ctrl_msg_d;
         status_send_val_q <= status_send_val_d;
         status_send_msg_q <= status_send_msg_d;
         busy_q            <= busy_d;
      end
   end

   assign cmd_recv_rdy    = cmd_recv_rdy_q;
   assign in_ctrl_val     = in_ctrl_val_q;
   assign in_ctrl_msg     = in_ctrl_msg_q;
   assign out_ctrl_val    = out_ctrl_val_q;
   assign out_ctrl_msg    = out_ctrl_msg_q;
   assign status_send_val = status_send_val_q;
   assign status_send_msg = status_send_msg_q;
   assign busy            = busy_q;

endmodule : fft_session_controller
`default_nettype wire

// File: tb/tb_fft_session_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fft_session_controller
//  Description : Self-checking bench for fft_session_controller. Stimulus is
//                randomized; expected status words come from a job-level
//                model (beats counted as they are driven, code chosen by how
//                the job ended).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_session_controller;

   localparam int N  = 32;
   localparam int CB = 6;
   localparam int TO = 4096;

   localparam logic [1:0] C_NOP = 2'd0, C_START = 2'd1, C_ABORT = 2'd2, C_STATUS = 2'd3;
   localparam logic [1:0] K_DONE = 2'b00, K_ABORT = 2'b01, K_TIMEOUT = 2'b10, K_QUERY = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cmd_recv_msg = '0;
   logic        cmd_recv_val = 1'b0;
   logic        cmd_recv_rdy;
   logic [1:0]  in_ctrl_msg;
   logic        in_ctrl_val;
   logic        in_ctrl_rdy = 1'b0;
   logic [1:0]  out_ctrl_msg;
   logic        out_ctrl_val;
   logic        out_ctrl_rdy = 1'b0;
   logic        in_beat_val = 1'b0, in_beat_rdy = 1'b0;
   logic        out_beat_val = 1'b0, out_beat_rdy = 1'b0;
   logic [15:0] status_send_msg;
   logic        status_send_val;
   logic        status_send_rdy = 1'b0;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;
   int model_in = 0;
   int model_out = 0;

   always #5 clk = ~clk;

   fft_session_controller #(
      .N_SAMPLES(N), .CNT_BITS(CB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_recv_msg(cmd_recv_msg), .cmd_recv_val(cmd_recv_val), .cmd_recv_rdy(cmd_recv_rdy),
      .in_ctrl_msg(in_ctrl_msg), .in_ctrl_val(in_ctrl_val), .in_ctrl_rdy(in_ctrl_rdy),
      .out_ctrl_msg(out_ctrl_msg), .out_ctrl_val(out_ctrl_val), .out_ctrl_rdy(out_ctrl_rdy),
      .in_beat_val(in_beat_val), .in_beat_rdy(in_beat_rdy),
      .out_beat_val(out_beat_val), .out_beat_rdy(out_beat_rdy),
      .status_send_msg(status_send_msg), .status_send_val(status_send_val),
      .status_send_rdy(status_send_rdy), .busy(busy)
   );

   // Status word layout: {code, in count, 00, out count}
   function automatic logic [15:0] exp_status(input logic [1:0] code, input int ic, input int oc);
      logic [5:0] a, b;
      a = ic[5:0];
      b = oc[5:0];
      return {code, a, 2'b00, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input string name);
      logic [15:0] r;
      int w;
      r = 16'($urandom());
      r[1:0] = op;
      cmd_recv_msg = r;
      cmd_recv_val = 1'b1;
      w = 0;
      while (!cmd_recv_rdy && w < 50) begin tick(); w++; end
      if (!cmd_recv_rdy) begin
         tests_run++; tests_failed++;
         $display("FAIL %s: cmd_recv_rdy never rose", name);
      end else begin
         tick();
      end
      cmd_recv_val = 1'b0;
   endtask

   // Wait for a crossbar control request, hold it off for 'delay' cycles, accept it
   task automatic handle_ctrl(input bit is_out, input logic [1:0] exp, input int delay, input string name);
      int w;
      logic [1:0] m;
      w = 0;
      while (!(is_out ? out_ctrl_val : in_ctrl_val) && w < 20) begin tick(); w++; end
      tests_run++;
      if (!(is_out ? out_ctrl_val : in_ctrl_val)) begin
         tests_failed++;
         $display("FAIL %s: ctrl val never rose", name);
         return;
      end
      m = is_out ? out_ctrl_msg : in_ctrl_msg;
      tests_run++;
      if (m !== exp) begin
         tests_failed++;
         $display("FAIL %s msg: got %b expected %b", name, m, exp);
      end
      for (int d = 0; d < delay; d++) begin
         tick();
         tests_run++;
         if ((is_out ? out_ctrl_val : in_ctrl_val) !== 1'b1 ||
             (is_out ? out_ctrl_msg : in_ctrl_msg) !== exp ||
             (is_out ? in_ctrl_val : out_ctrl_val) !== 1'b0 ||
             cmd_recv_rdy !== 1'b0 || busy !== 1'b1 || status_send_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s hold: val=%b msg=%b other_val=%b cmd_rdy=%b busy=%b st_val=%b expected 1 %b 0 0 1 0",
                     name, is_out ? out_ctrl_val : in_ctrl_val, is_out ? out_ctrl_msg : in_ctrl_msg,
                     is_out ? in_ctrl_val : out_ctrl_val, cmd_recv_rdy, busy, status_send_val, exp);
         end
      end
      if (is_out) out_ctrl_rdy = 1'b1; else in_ctrl_rdy = 1'b1;
      tick();
      out_ctrl_rdy = 1'b0;
      in_ctrl_rdy  = 1'b0;
      tests_run++;
      if ((is_out ? out_ctrl_val : in_ctrl_val) !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s drop: val=%b after accept, expected 0", name, is_out ? out_ctrl_val : in_ctrl_val);
      end
   endtask

   task automatic expect_status(input logic [15:0] exp, input int delay, input string name);
      int w;
      w = 0;
      while (!status_send_val && w < 30) begin tick(); w++; end
      tests_run++;
      if (!status_send_val) begin
         tests_failed++;
         $display("FAIL %s: status val never rose", name);
         return;
      end
      tests_run++;
      if (status_send_msg !== exp) begin
         tests_failed++;
         $display("FAIL %s status: got %h expected %h", name, status_send_msg, exp);
      end
      for (int d = 0; d < delay; d++) begin
         tick();
         tests_run++;
         if (status_send_val !== 1'b1 || status_send_msg !== exp || cmd_recv_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s status hold: val=%b msg=%h cmd_rdy=%b expected 1 %h 0",
                     name, status_send_val, status_send_msg, cmd_recv_rdy, exp);
         end
      end
      status_send_rdy = 1'b1;
      tick();
      status_send_rdy = 1'b0;
      tests_run++;
      if (status_send_val !== 1'b0 || busy !== 1'b0 || cmd_recv_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s idle return: st_val=%b busy=%b cmd_rdy=%b expected 0 0 1",
                  name, status_send_val, busy, cmd_recv_rdy);
      end
   endtask

   task automatic start_job(input int d_in, input int d_out, input string name);
      send_cmd(C_START, name);
      model_in  = 0;
      model_out = 0;
      tests_run++;
      if (in_ctrl_val !== 1'b1 || in_ctrl_msg !== 2'b01 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s first cfg: in_val=%b msg=%b busy=%b expected 1 01 1",
                  name, in_ctrl_val, in_ctrl_msg, busy);
      end
      handle_ctrl(1'b0, 2'b01, d_in, name);
      handle_ctrl(1'b1, 2'b10, d_out, name);
   endtask

   // Drive random in-beat traffic (out-beats meanwhile are noise) until n fire
   task automatic drive_in_beats(input int n, input string name);
      int cnt, cyc;
      cnt = 0; cyc = 0;
      while (cnt < n && cyc < 20 * n + 50) begin
         in_beat_val  = 1'($urandom_range(0, 1));
         in_beat_rdy  = ($urandom_range(0, 3) != 0);
         out_beat_val = 1'($urandom_range(0, 1));
         out_beat_rdy = 1'($urandom_range(0, 1));
         if (in_beat_val && in_beat_rdy) cnt++;
         tick();
         cyc++;
      end
      in_beat_val = 1'b0; in_beat_rdy = 1'b0; out_beat_val = 1'b0; out_beat_rdy = 1'b0;
      model_in = (model_in + cnt > N) ? N : model_in + cnt;
      tests_run++;
      if (cnt != n || busy !== 1'b1 || cmd_recv_rdy !== 1'b1 || in_ctrl_val !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s in beats: fired=%0d busy=%b cmd_rdy=%b in_val=%b expected %0d 1 1 0",
                  name, cnt, busy, cmd_recv_rdy, in_ctrl_val, n);
      end
   endtask

   task automatic drive_out_beats(input int n);
      int cnt, cyc;
      cnt = 0; cyc = 0;
      while (cnt < n && cyc < 20 * n + 50) begin
         out_beat_val = 1'($urandom_range(0, 1));
         out_beat_rdy = ($urandom_range(0, 3) != 0);
         in_beat_val  = 1'($urandom_range(0, 1));
         in_beat_rdy  = 1'($urandom_range(0, 1));
         if (out_beat_val && out_beat_rdy) cnt++;
         tick();
         cyc++;
      end
      in_beat_val = 1'b0; in_beat_rdy = 1'b0; out_beat_val = 1'b0; out_beat_rdy = 1'b0;
      model_out = (model_out + cnt > N) ? N : model_out + cnt;
   endtask

   task automatic finish_job(input logic [1:0] code, input int d1, input int d2, input int d3, input string name);
      handle_ctrl(1'b0, 2'b00, d1, name);
      handle_ctrl(1'b1, 2'b00, d2, name);
      expect_status(exp_status(code, model_in, model_out), d3, name);
   endtask

   task automatic wait_watchdog(input string name);
      int cyc;
      cyc = 0;
      while (!in_ctrl_val && cyc < TO + 100) begin tick(); cyc++; end
      tests_run++;
      if (cyc != TO) begin
         tests_failed++;
         $display("FAIL %s watchdog: restore after %0d idle cycles, expected %0d", name, cyc, TO);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      model_in = 0; model_out = 0;
      tests_run++;
      if (in_ctrl_val !== 1'b0 || out_ctrl_val !== 1'b0 || status_send_val !== 1'b0 ||
          busy !== 1'b0 || cmd_recv_rdy !== 1'b1 || in_ctrl_msg !== 2'b00 ||
          out_ctrl_msg !== 2'b00 || status_send_msg !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset: vals=%b%b%b busy=%b cmd_rdy=%b msgs=%b %b %h expected 000 0 1 00 00 0000",
                  in_ctrl_val, out_ctrl_val, status_send_val, busy, cmd_recv_rdy,
                  in_ctrl_msg, out_ctrl_msg, status_send_msg);
      end
   endtask

   task automatic test_status_idle(input string name);
      send_cmd(C_NOP, name);
      tests_run++;
      if (busy !== 1'b0 || status_send_val !== 1'b0 || in_ctrl_val !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s nop: busy=%b st_val=%b in_val=%b expected 0 0 0", name, busy, status_send_val, in_ctrl_val);
      end
      status_send_rdy = 1'b1;
      send_cmd(C_STATUS, name);
      tests_run++;
      if (status_send_val !== 1'b1 || status_send_msg !== exp_status(K_QUERY, model_in, model_out)) begin
         tests_failed++;
         $display("FAIL %s query: val=%b msg=%h expected 1 %h", name, status_send_val, status_send_msg,
                  exp_status(K_QUERY, model_in, model_out));
      end
      tick();
      status_send_rdy = 1'b0;
      tests_run++;
      if (status_send_val !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s query pulse: val=%b busy=%b expected 0 0", name, status_send_val, busy);
      end
   endtask

   task automatic test_full_job(input bit random_delays, input string name);
      int d[5];
      for (int i = 0; i < 5; i++) d[i] = random_delays ? $urandom_range(0, 4) : 0;
      start_job(d[0], d[1], name);
      drive_in_beats(N, name);
      drive_out_beats(N);
      finish_job(K_DONE, d[2], d[3], d[4], name);
   endtask

   task automatic test_abort_load();
      start_job(0, 0, "abort_load");
      drive_in_beats(10, "abort_load");
      cmd_recv_msg = 16'hFFFC | 16'(C_ABORT);
      cmd_recv_val = 1'b1;
      in_beat_val  = 1'b1;
      in_beat_rdy  = 1'b1;
      tick();
      cmd_recv_val = 1'b0; in_beat_val = 1'b0; in_beat_rdy = 1'b0;
      model_in++;
      finish_job(K_ABORT, 0, 0, 0, "abort_load");
   endtask

   task automatic test_abort_drain();
      int k;
      k = $urandom_range(0, N - 2);
      start_job(1, 1, "abort_drain");
      drive_in_beats(N, "abort_drain");
      drive_out_beats(k);
      cmd_recv_msg = {14'($urandom()), C_ABORT};
      cmd_recv_val = 1'b1;
      out_beat_val = 1'b1;
      out_beat_rdy = 1'b1;
      tick();
      cmd_recv_val = 1'b0; out_beat_val = 1'b0; out_beat_rdy = 1'b0;
      model_out++;
      finish_job(K_ABORT, 2, 1, 2, "abort_drain");
   endtask

   task automatic test_ignored_cmds();
      start_job(0, 0, "ignored_cmds");
      drive_in_beats($urandom_range(1, 8), "ignored_cmds");
      send_cmd(C_STATUS, "ignored_cmds");
      send_cmd(C_START, "ignored_cmds");
      tick();
      tests_run++;
      if (status_send_val !== 1'b0 || in_ctrl_val !== 1'b0 || busy !== 1'b1 || cmd_recv_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL ignored_cmds: st_val=%b in_val=%b busy=%b cmd_rdy=%b expected 0 0 1 1",
                  status_send_val, in_ctrl_val, busy, cmd_recv_rdy);
      end
      drive_in_beats(N - model_in, "ignored_cmds");
      drive_out_beats(N);
      finish_job(K_DONE, 0, 0, 0, "ignored_cmds");
   endtask

   task automatic test_timeout_drain();
      start_job(0, 0, "timeout_drain");
      drive_in_beats(N, "timeout_drain");
      drive_out_beats(5);
      wait_watchdog("timeout_drain");
      finish_job(K_TIMEOUT, 0, 0, 0, "timeout_drain");
   endtask

   task automatic test_timeout_load();
      start_job(0, 0, "timeout_load");
      drive_in_beats(7, "timeout_load");
      wait_watchdog("timeout_load");
      finish_job(K_TIMEOUT, 1, 0, 1, "timeout_load");
   endtask

   task automatic test_backpressure();
      start_job(7, 3, "backpressure");
      drive_in_beats(N, "backpressure");
      drive_out_beats(N);
      finish_job(K_DONE, 7, 5, 4, "backpressure");
   endtask

   task automatic test_reset_mid_drain();
      start_job(0, 0, "reset_mid_drain");
      drive_in_beats(N, "reset_mid_drain");
      drive_out_beats(3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_in = 0; model_out = 0;
      tests_run++;
      if (in_ctrl_val !== 1'b0 || out_ctrl_val !== 1'b0 || status_send_val !== 1'b0 ||
          busy !== 1'b0 || cmd_recv_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_drain: vals=%b%b%b busy=%b cmd_rdy=%b expected 000 0 1",
                  in_ctrl_val, out_ctrl_val, status_send_val, busy, cmd_recv_rdy);
      end
      tick();
      test_status_idle("post_reset_query");
      test_full_job(1'b1, "post_reset_job");
   endtask

   initial begin
      test_reset();
      test_status_idle("idle_query");
      test_full_job(1'b0, "full_job");
      test_status_idle("last_job_query");
      test_abort_load();
      test_abort_drain();
      test_ignored_cmds();
      test_timeout_drain();
      test_timeout_load();
      test_backpressure();
      test_reset_mid_drain();
      for (int j = 0; j < 3; j++) test_full_job(1'b1, "back_to_back");
      test_status_idle("final_query");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule : tb_fft_session_controller
`default_nettype wire
